// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper driver and phase monitor:
// coil encodings, monitor states and the one-hot phase decoder.
package stepper_pkg;

    localparam logic [3:0] PHASE_0   = 4'b0001;
    localparam logic [3:0] PHASE_1   = 4'b0010;
    localparam logic [3:0] PHASE_2   = 4'b0100;
    localparam logic [3:0] PHASE_3   = 4'b1000;
    localparam logic [3:0] PHASE_OFF = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       off;
    } phase_dec_t;

    // Anything that is neither one-hot nor all-off decodes as invalid.
    function automatic phase_dec_t phase_to_idx(input logic [3:0] phase);
        phase_dec_t d;
        d = '0;
        case (phase)
            PHASE_0:   begin d.idx = 2'd0; d.valid = 1'b1; end
            PHASE_1:   begin d.idx = 2'd1; d.valid = 1'b1; end
            PHASE_2:   begin d.idx = 2'd2; d.valid = 1'b1; end
            PHASE_3:   begin d.idx = 2'd3; d.valid = 1'b1; end
            PHASE_OFF: d.off = 1'b1;
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stepper_phase_monitor_if.sv
// Bundle between the step driver side and the phase monitor.
interface stepper_phase_monitor_if #(
    parameter int POS_W = 16
);
    logic [3:0]       phase;
    logic             clr_fault;
    logic             pos_clr;
    logic             step_pulse;
    logic             step_dir;
    logic [POS_W-1:0] position;
    logic             tracking;
    logic             fault;
    logic             stalled;

    modport master (
        output phase, clr_fault, pos_clr,
        input  step_pulse, step_dir, position, tracking, fault, stalled
    );

    modport slave (
        input  phase, clr_fault, pos_clr,
        output step_pulse, step_dir, position, tracking, fault, stalled
    );

endinterface

// File: rtl/stepper_stall_timer.sv
// Saturating cycle counter; expired holds while the count sits at LIMIT.
module stepper_stall_timer #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == MAX);

endmodule

// File: rtl/stepper_phase_monitor.sv
// Reconstructs step events, direction and position from the registered
// coil pattern; flags illegal patterns, skipped phases and stalls.
module stepper_phase_monitor
    import stepper_pkg::*;
#(
    parameter int POS_W        = 16,
    parameter int STALL_CYCLES = 1_000_000
) (
    input logic                    clk,
    input logic                    rst,
    stepper_phase_monitor_if.slave bus
);
    logic [3:0]       phase_q;
    logic [1:0]       last_idx;
    state_t           state;
    logic             step_pulse_r;
    logic             step_dir_r;
    logic             tracking_r;
    logic             fault_r;
    logic [POS_W-1:0] position_r;
    phase_dec_t       dec;
    logic [1:0]       delta;
    logic             stall_inc;
    logic             stall_expired;

    assign dec       = phase_to_idx(phase_q);
    assign delta     = dec.idx - last_idx;
    assign stall_inc = (state == TRACK) && dec.valid && (delta == 2'd0);

    // Only a held phase in TRACK keeps counting; steps and exits restart it.
    stepper_stall_timer #(
        .LIMIT (STALL_CYCLES)
    ) u_stall (
        .clk     (clk),
        .rst     (rst),
        .clr     (!stall_inc),
        .inc     (stall_inc),
        .expired (stall_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= PHASE_OFF;
            last_idx     <= 2'd0;
            state        <= IDLE;
            step_pulse_r <= 1'b0;
            step_dir_r   <= 1'b0;
            position_r   <= '0;
            tracking_r   <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            phase_q      <= bus.phase;
            step_pulse_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (dec.valid) begin
                        last_idx   <= dec.idx;
                        state      <= TRACK;
                        tracking_r <= 1'b1;
                    end else if (!dec.off) begin
                        state   <= FAULT;
                        fault_r <= 1'b1;
                    end
                end
                TRACK: begin
                    if (dec.off) begin
                        state      <= IDLE;
                        tracking_r <= 1'b0;
                    end else if (!dec.valid || (delta == 2'd2)) begin
                        state      <= FAULT;
                        tracking_r <= 1'b0;
                        fault_r    <= 1'b1;
                    end else if (delta == 2'd3) begin
                        step_pulse_r <= 1'b1;
                        step_dir_r   <= 1'b0;
                        position_r   <= position_r + POS_W'(1);
                        last_idx     <= dec.idx;
                    end else if (delta == 2'd1) begin
                        step_pulse_r <= 1'b1;
                        step_dir_r   <= 1'b1;
                        position_r   <= position_r - POS_W'(1);
                        last_idx     <= dec.idx;
                    end
                end
                FAULT: begin
                    if (bus.clr_fault) begin
                        state   <= IDLE;
                        fault_r <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // A coincident clear wins over the step's position update.
            if (bus.pos_clr) begin
                position_r <= '0;
            end
        end
    end

    assign bus.step_pulse = step_pulse_r;
    assign bus.step_dir   = step_dir_r;
    assign bus.position   = position_r;
    assign bus.tracking   = tracking_r;
    assign bus.fault      = fault_r;
    assign bus.stalled    = stall_expired;

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Self-checking bench for stepper_phase_monitor: directed scenarios plus a
// randomized run compared against a behavioural model.
module tb_stepper_phase_monitor;

    localparam int POS_W = 8;
    localparam int STALL = 8;
    localparam int MASK  = (1 << POS_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stepper_phase_monitor_if #(.POS_W(POS_W)) bus ();

    stepper_phase_monitor #(
        .POS_W        (POS_W),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: sampled pattern, energized/faulted flags,
    // last coil index, position, held-cycle count, last step info.
    logic [3:0] m_phq;
    bit         m_on, m_flt, m_pulse, m_dir;
    int         m_last, m_pos, m_stall;

    task automatic model_reset();
        m_phq = 4'b0; m_on = 0; m_flt = 0; m_pulse = 0; m_dir = 0;
        m_last = 0; m_pos = 0; m_stall = 0;
    endtask

    task automatic model_edge(input logic [3:0] ph, input bit pc, input bit cf);
        bit held;
        int d, ni;
        held = 0;
        m_pulse = 0;
        ni = 0;
        for (int i = 0; i < 4; i++) if (m_phq[i]) ni = i;
        if (m_flt) begin
            if (cf) m_flt = 0;
        end else if (m_phq == 4'b0) begin
            m_on = 0;
        end else if ($countones(m_phq) != 1) begin
            m_flt = 1; m_on = 0;
        end else if (!m_on) begin
            m_on = 1; m_last = ni;
        end else begin
            d = (ni - m_last + 4) % 4;
            if (d == 0) held = 1;
            else if (d == 2) begin m_flt = 1; m_on = 0; end
            else begin
                m_pulse = 1;
                m_dir   = (d == 1);
                m_pos   = m_pos + ((d == 3) ? 1 : -1);
                m_last  = ni;
            end
        end
        m_stall = held ? ((m_stall < STALL) ? m_stall + 1 : STALL) : 0;
        if (pc) m_pos = 0;
        m_pos = m_pos & MASK;
        m_phq = ph;
    endtask

    task automatic advance(input logic [3:0] ph, input bit pc = 0, input bit cf = 0);
        bus.phase = ph; bus.pos_clr = pc; bus.clr_fault = cf;
        @(posedge clk);
        if (rst) model_reset(); else model_edge(ph, pc, cf);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        advance(4'b0000);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance(4'b1000);
        advance(4'b1000, 1, 1);
        rst = 1'b0;
        n_checks++; if (bus.step_pulse !== 1'b0) $display("[TB] FAIL reset_pulse got=%b exp=0", bus.step_pulse); else n_pass++;
        n_checks++; if (bus.step_dir !== 1'b0) $display("[TB] FAIL reset_dir got=%b exp=0", bus.step_dir); else n_pass++;
        n_checks++; if (bus.position !== '0) $display("[TB] FAIL reset_position got=%h exp=0", bus.position); else n_pass++;
        n_checks++; if (bus.tracking !== 1'b0) $display("[TB] FAIL reset_tracking got=%b exp=0", bus.tracking); else n_pass++;
        n_checks++; if (bus.fault !== 1'b0) $display("[TB] FAIL reset_fault got=%b exp=0", bus.fault); else n_pass++;
        n_checks++; if (bus.stalled !== 1'b0) $display("[TB] FAIL reset_stalled got=%b exp=0", bus.stalled); else n_pass++;
    endtask

    task automatic test_forward();
        logic [3:0] seq [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        int pulses, first_pulses, bad_dir;
        pulses = 0; first_pulses = 0; bad_dir = 0;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            repeat (4) begin
                advance(seq[s]);
                if (bus.step_pulse === 1'b1) begin
                    pulses++;
                    if (s == 0) first_pulses++;
                    if (bus.step_dir !== 1'b0) bad_dir++;
                end
            end
        end
        n_checks++; if (first_pulses != 0) $display("[TB] FAIL fwd_first_energize got=%0d exp=0", first_pulses); else n_pass++;
        n_checks++; if (pulses != 4) $display("[TB] FAIL fwd_pulses got=%0d exp=4", pulses); else n_pass++;
        n_checks++; if (bad_dir != 0) $display("[TB] FAIL fwd_dir got=%0d exp=0", bad_dir); else n_pass++;
        n_checks++; if (bus.position !== POS_W'(4)) $display("[TB] FAIL fwd_position got=%h exp=04", bus.position); else n_pass++;
        n_checks++; if (bus.tracking !== 1'b1) $display("[TB] FAIL fwd_tracking got=%b exp=1", bus.tracking); else n_pass++;
    endtask

    task automatic test_reverse_idle();
        int pulses, rev;
        pulses = 0; rev = 0;
        do_reset();
        repeat (3) advance(4'b0001);
        repeat (3) begin advance(4'b0010); if (bus.step_pulse === 1'b1) begin pulses++; if (bus.step_dir === 1'b1) rev++; end end
        repeat (3) begin advance(4'b0100); if (bus.step_pulse === 1'b1) begin pulses++; if (bus.step_dir === 1'b1) rev++; end end
        n_checks++; if (pulses != 2) $display("[TB] FAIL rev_pulses got=%0d exp=2", pulses); else n_pass++;
        n_checks++; if (rev != 2) $display("[TB] FAIL rev_dir got=%0d exp=2", rev); else n_pass++;
        n_checks++; if (bus.position !== 8'hFE) $display("[TB] FAIL rev_position got=%h exp=fe", bus.position); else n_pass++;
        repeat (3) advance(4'b0000);
        n_checks++; if (bus.tracking !== 1'b0) $display("[TB] FAIL idle_tracking got=%b exp=0", bus.tracking); else n_pass++;
        n_checks++; if (bus.position !== 8'hFE) $display("[TB] FAIL idle_position got=%h exp=fe", bus.position); else n_pass++;
        pulses = 0;
        repeat (3) begin advance(4'b0100); if (bus.step_pulse === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) $display("[TB] FAIL reacquire_pulses got=%0d exp=0", pulses); else n_pass++;
        n_checks++; if (bus.tracking !== 1'b1) $display("[TB] FAIL reacquire_tracking got=%b exp=1", bus.tracking); else n_pass++;
    endtask

    task automatic test_fault();
        do_reset();
        repeat (3) advance(4'b0001);
        repeat (3) advance(4'b0100);
        n_checks++; if (bus.fault !== 1'b1) $display("[TB] FAIL skip_fault got=%b exp=1", bus.fault); else n_pass++;
        n_checks++; if (bus.position !== '0) $display("[TB] FAIL skip_position got=%h exp=0", bus.position); else n_pass++;
        n_checks++; if (bus.tracking !== 1'b0) $display("[TB] FAIL skip_tracking got=%b exp=0", bus.tracking); else n_pass++;
        repeat (3) advance(4'b0110);
        repeat (3) advance(4'b0001);
        n_checks++; if (bus.fault !== 1'b1) $display("[TB] FAIL fault_sticky got=%b exp=1", bus.fault); else n_pass++;
        advance(4'b0001, 0, 1);
        n_checks++; if (bus.fault !== 1'b0) $display("[TB] FAIL clr_fault got=%b exp=0", bus.fault); else n_pass++;
        n_checks++; if (bus.tracking !== 1'b0) $display("[TB] FAIL clr_to_idle got=%b exp=0", bus.tracking); else n_pass++;
        advance(4'b0001);
        advance(4'b0001, 0, 1);
        n_checks++; if (bus.tracking !== 1'b1 || bus.fault !== 1'b0) $display("[TB] FAIL clr_in_track got=%b%b exp=10", bus.tracking, bus.fault); else n_pass++;
        repeat (2) advance(4'b0000);
        repeat (2) advance(4'b0011);
        n_checks++; if (bus.fault !== 1'b1) $display("[TB] FAIL idle_invalid got=%b exp=1", bus.fault); else n_pass++;
    endtask

    task automatic test_wrap();
        int idx, pulses;
        idx = 0; pulses = 0;
        do_reset();
        repeat (2) advance(4'b0001);
        for (int i = 0; i < 127; i++) begin
            idx = (idx + 3) % 4;
            advance(4'(1 << idx));
            if (bus.step_pulse === 1'b1) pulses++;
        end
        advance(4'(1 << idx));
        if (bus.step_pulse === 1'b1) pulses++;
        n_checks++; if (pulses != 127) $display("[TB] FAIL back_to_back_pulses got=%0d exp=127", pulses); else n_pass++;
        n_checks++; if (bus.position !== 8'h7F) $display("[TB] FAIL wrap_preload got=%h exp=7f", bus.position); else n_pass++;
        idx = (idx + 3) % 4;
        advance(4'(1 << idx));
        advance(4'(1 << idx));
        n_checks++; if (bus.position !== 8'h80) $display("[TB] FAIL wrap_position got=%h exp=80", bus.position); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (9) advance(4'b1000);
        n_checks++; if (bus.stalled !== 1'b0) $display("[TB] FAIL stall_early got=%b exp=0", bus.stalled); else n_pass++;
        advance(4'b1000);
        n_checks++; if (bus.stalled !== 1'b1) $display("[TB] FAIL stall_assert got=%b exp=1", bus.stalled); else n_pass++;
        repeat (3) advance(4'b1000);
        n_checks++; if (bus.stalled !== 1'b1) $display("[TB] FAIL stall_saturate got=%b exp=1", bus.stalled); else n_pass++;
        advance(4'b0100);
        advance(4'b0100);
        n_checks++; if (bus.step_pulse !== 1'b1 || bus.stalled !== 1'b0) $display("[TB] FAIL stall_clear got=%b%b exp=10", bus.step_pulse, bus.stalled); else n_pass++;
    endtask

    task automatic test_pos_clr();
        do_reset();
        repeat (2) advance(4'b0001);
        repeat (2) advance(4'b1000);
        advance(4'b0100);
        advance(4'b0100, 1, 0);
        n_checks++; if (bus.position !== '0) $display("[TB] FAIL posclr_position got=%h exp=0", bus.position); else n_pass++;
        n_checks++; if (bus.step_pulse !== 1'b1 || bus.step_dir !== 1'b0) $display("[TB] FAIL posclr_step got=%b%b exp=10", bus.step_pulse, bus.step_dir); else n_pass++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (2) advance(4'b0001);
        advance(4'b0010);
        advance(4'b0100);
        advance(4'b0010);
        rst = 1'b1;
        advance(4'b0001);
        rst = 1'b0;
        n_checks++; if ({bus.step_pulse, bus.step_dir, bus.tracking, bus.fault, bus.stalled} !== 5'b0 || bus.position !== '0)
            $display("[TB] FAIL rst_mid got=%b%b%b%b%b pos=%h exp=00000 pos=0", bus.step_pulse, bus.step_dir, bus.tracking, bus.fault, bus.stalled, bus.position);
        else n_pass++;
        advance(4'b0010);
        advance(4'b0010);
        n_checks++; if (bus.tracking !== 1'b1 || bus.step_pulse !== 1'b0 || bus.position !== '0)
            $display("[TB] FAIL rst_reacquire got=%b%b pos=%h exp=10 pos=0", bus.tracking, bus.step_pulse, bus.position);
        else n_pass++;
    endtask

    task automatic test_random();
        int idx, r;
        logic [3:0] ph;
        bit pc, cf;
        idx = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) idx = (idx + 3) % 4;
            else if (r < 65) idx = (idx + 1) % 4;
            else if (r < 92 && r >= 87) idx = (idx + 2) % 4;
            ph = 4'(1 << idx);
            if (r >= 80 && r < 87) ph = 4'b0000;
            if (r >= 92 && r < 96) ph = 4'($urandom_range(0, 15));
            cf = ($urandom_range(0, 9) == 0);
            pc = ($urandom_range(0, 29) == 0);
            advance(ph, pc, cf);
            n_checks++; if (bus.step_pulse !== m_pulse) $display("[TB] FAIL rnd_pulse cyc=%0d got=%b exp=%b", i, bus.step_pulse, m_pulse); else n_pass++;
            n_checks++; if (bus.step_dir !== m_dir) $display("[TB] FAIL rnd_dir cyc=%0d got=%b exp=%b", i, bus.step_dir, m_dir); else n_pass++;
            n_checks++; if (bus.position !== POS_W'(m_pos)) $display("[TB] FAIL rnd_position cyc=%0d got=%h exp=%h", i, bus.position, POS_W'(m_pos)); else n_pass++;
            n_checks++; if (bus.tracking !== m_on) $display("[TB] FAIL rnd_tracking cyc=%0d got=%b exp=%b", i, bus.tracking, m_on); else n_pass++;
            n_checks++; if (bus.fault !== m_flt) $display("[TB] FAIL rnd_fault cyc=%0d got=%b exp=%b", i, bus.fault, m_flt); else n_pass++;
            n_checks++; if (bus.stalled !== (m_stall == STALL)) $display("[TB] FAIL rnd_stalled cyc=%0d got=%b exp=%b", i, bus.stalled, (m_stall == STALL)); else n_pass++;
        end
    endtask

    initial begin
        bus.phase = 4'b0000;
        bus.pos_clr = 1'b0;
        bus.clr_fault = 1'b0;
        model_reset();
        test_reset();
        test_forward();
        test_reverse_idle();
        test_fault();
        test_wrap();
        test_stall();
        test_pos_clr();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
